// File: rtl/perf_pkg.sv
// Shared constants and FSM encoding for the performance monitor.
package perf_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned N_EVT_DEF  = 4;
  localparam int unsigned FRAC_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } perf_state_e;

endpackage

// File: rtl/perf_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, DVD_W cycles per divide.
// done pulses on the final iteration and quotient carries the finished result that cycle.
module perf_seq_divider #(
  parameter int DVD_W = 40,
  parameter int DVS_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W:0]   rem_shift;
  logic             ge;

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    done      = 1'b0;
    // Dividend bits shift out of the top of quo_q while quotient bits enter at the bottom.
    rem_shift = {rem_q, quo_q[DVD_W-1]};
    ge        = (rem_shift >= {1'b0, dvs_q});
    if (busy_q) begin
      if (ge) begin
        rem_d = DVS_W'(rem_shift - {1'b0, dvs_q});
      end else begin
        rem_d = rem_shift[DVS_W-1:0];
      end
      quo_d = {quo_q[DVD_W-2:0], ge};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(DVD_W);
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_d;

endmodule

// File: rtl/perf_monitor_unit.sv
// Saturating cycle/instruction/event counters with snapshot capture and fixed-point CPI.
// Live counters index 0 = cycles, 1 = instr, 2+i = event i, matching the ovf bit layout.
module perf_monitor_unit
  import perf_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int N_EVT  = N_EVT_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   instr_retire,
  input  logic [N_EVT-1:0]       evt_inc,
  input  logic                   snapshot_req,
  output logic [CNT_W-1:0]       snap_cycles,
  output logic [CNT_W-1:0]       snap_instr,
  output logic [N_EVT*CNT_W-1:0] snap_evt,
  output logic [CNT_W-1:0]       cpi_q,
  output logic                   cpi_valid,
  output logic                   div_by_zero,
  output logic                   busy,
  output logic [N_EVT+1:0]       ovf
);

  localparam int NC = N_EVT + 2;
  localparam int DW = CNT_W + FRAC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NC-1:0][CNT_W-1:0] live_q, live_d;
  logic [NC-1:0][CNT_W-1:0] snap_q, snap_d;
  logic [NC-1:0]            ovf_q, ovf_d;
  logic [NC-1:0]            strobe;
  logic [CNT_W-1:0]         cpi_reg_q, cpi_reg_d;
  logic                     dbz_q, dbz_d;
  perf_state_e              state_q, state_d;

  logic          div_start, div_busy, div_done;
  logic [DW-1:0] div_quo;

  assign strobe = {evt_inc, instr_retire, 1'b1};

  always_comb begin
    live_d = live_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < NC; i++) begin
      if (enable && strobe[i]) begin
        if (live_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          live_d[i] = live_q[i] + CNT_W'(1);
        end
      end
    end
    if (clear) begin
      live_d = '0;
      ovf_d  = '0;
    end
  end

  // The divider starts from the live values, which are exactly what snap_q captures this edge.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cpi_reg_d = cpi_reg_q;
    dbz_d     = dbz_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (snapshot_req) begin
          snap_d = live_q;
          if (live_q[1] == '0) begin
            state_d   = ST_DONE;
            cpi_reg_d = '1;
            dbz_d     = 1'b1;
          end else begin
            state_d   = ST_DIVIDE;
            div_start = 1'b1;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          state_d   = ST_DONE;
          cpi_reg_d = (|div_quo[DW-1:CNT_W]) ? '1 : div_quo[CNT_W-1:0];
          dbz_d     = 1'b0;
        end else if (!div_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= '0;
      snap_q    <= '0;
      ovf_q     <= '0;
      cpi_reg_q <= '0;
      dbz_q     <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      live_q    <= live_d;
      snap_q    <= snap_d;
      ovf_q     <= ovf_d;
      cpi_reg_q <= cpi_reg_d;
      dbz_q     <= dbz_d;
      state_q   <= state_d;
    end
  end

  perf_seq_divider #(
    .DVD_W(DW),
    .DVS_W(CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend({live_q[0], FRAC_W'(0)}),
    .divisor (live_q[1]),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  assign snap_cycles = snap_q[0];
  assign snap_instr  = snap_q[1];
  assign snap_evt    = snap_q[NC-1:2];
  assign cpi_q       = cpi_reg_q;
  assign cpi_valid   = (state_q == ST_DONE);
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != ST_IDLE);
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_perf_monitor_unit.sv
// Bench for perf_monitor_unit: abstract count/latency model checked every cycle plus directed scenarios.
module tb_perf_monitor_unit;

  localparam int FRAC = 8;
  localparam int LAT  = 32 + FRAC + 1;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 0, clear = 0, instr_retire = 0, snapshot_req = 0;
  logic [3:0]  evt_inc = '0;
  logic [31:0] snap_cycles, snap_instr, cpi_q;
  logic [127:0] snap_evt;
  logic        cpi_valid, div_by_zero, busy;
  logic [5:0]  ovf;

  logic        en8 = 0, clr8 = 0, snap8 = 0, instr8 = 0;
  logic [3:0]  evt8 = '0;
  logic [7:0]  snap_cycles8, snap_instr8, cpi_q8;
  logic [31:0] snap_evt8;
  logic        cpi_valid8, dbz8, busy8;
  logic [5:0]  ovf8;

  perf_monitor_unit u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .instr_retire(instr_retire),
    .evt_inc(evt_inc), .snapshot_req(snapshot_req), .snap_cycles(snap_cycles),
    .snap_instr(snap_instr), .snap_evt(snap_evt), .cpi_q(cpi_q), .cpi_valid(cpi_valid),
    .div_by_zero(div_by_zero), .busy(busy), .ovf(ovf)
  );

  perf_monitor_unit #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .clear(clr8), .instr_retire(instr8),
    .evt_inc(evt8), .snapshot_req(snap8), .snap_cycles(snap_cycles8),
    .snap_instr(snap_instr8), .snap_evt(snap_evt8), .cpi_q(cpi_q8), .cpi_valid(cpi_valid8),
    .div_by_zero(dbz8), .busy(busy8), .ovf(ovf8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cpi_of(input longint unsigned c, input longint unsigned n);
    longint unsigned q;
    q = (c << FRAC) / n;
    return (q > MAXV) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  // Model: counts as integers, timer = cycles left until the result is presented.
  longint unsigned m_live [6] = '{default: 0};
  longint unsigned m_snap [6] = '{default: 0};
  logic [5:0]  m_ovf = '0;
  int          m_timer = 0;
  logic [31:0] m_cpi = '0, m_cpi_next = '0;
  logic        m_dbz = 1'b0, m_dbz_next = 1'b0;
  logic [5:0]  m_strb;
  assign m_strb = {evt_inc, instr_retire, 1'b1};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        m_live[i] <= 0;
        m_snap[i] <= 0;
      end
      m_ovf <= '0; m_timer <= 0; m_cpi <= '0; m_cpi_next <= '0; m_dbz <= 0; m_dbz_next <= 0;
    end else begin
      if (m_timer == 0 && snapshot_req) begin
        for (int i = 0; i < 6; i++) m_snap[i] <= m_live[i];
        if (m_live[1] == 0) begin
          m_timer <= 1; m_cpi_next <= 32'hFFFF_FFFF; m_dbz_next <= 1'b1;
        end else begin
          m_timer <= LAT; m_cpi_next <= cpi_of(m_live[0], m_live[1]); m_dbz_next <= 1'b0;
        end
      end else if (m_timer > 0) begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) begin
          m_cpi <= m_cpi_next;
          m_dbz <= m_dbz_next;
        end
      end
      for (int i = 0; i < 6; i++) begin
        if (enable && m_strb[i]) begin
          if (m_live[i] == MAXV) m_ovf[i] <= 1'b1;
          else m_live[i] <= m_live[i] + 1;
        end
      end
      if (clear) begin
        for (int i = 0; i < 6; i++) m_live[i] <= 0;
        m_ovf <= '0;
      end
    end
  end

  initial begin
    @(posedge rst_n);
    forever begin
      @(posedge clk);
      #1;
      chk("m_snap_cycles", 64'(snap_cycles), m_snap[0]);
      chk("m_snap_instr", 64'(snap_instr), m_snap[1]);
      for (int i = 0; i < 4; i++) chk("m_snap_evt", 64'(snap_evt[i*32 +: 32]), m_snap[2+i]);
      chk("m_busy", 64'(busy), 64'(m_timer > 0));
      chk("m_cpi_valid", 64'(cpi_valid), 64'(m_timer == 1));
      chk("m_cpi_q", 64'(cpi_q), 64'((m_timer == 1) ? m_cpi_next : m_cpi));
      chk("m_div_by_zero", 64'(div_by_zero), 64'((m_timer == 1) ? m_dbz_next : m_dbz));
      chk("m_ovf", 64'(ovf), 64'(m_ovf));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  int pulses;

  initial begin
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpi_valid", 64'(cpi_valid), 64'd0);
    chk("rst_cpi_q", 64'(cpi_q), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 enabled cycles, retire every 5th: CPI 5.0
    enable = 1;
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i % 5 == 4);
      evt_inc = 4'(i);
      @(negedge clk);
    end
    enable = 0; instr_retire = 0; evt_inc = '0; snapshot_req = 1;
    @(negedge clk);
    snapshot_req = 0;
    pulses = 0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 1) begin
        chk("t1_snap_cycles", 64'(snap_cycles), 64'd100);
        chk("t1_snap_instr", 64'(snap_instr), 64'd20);
        chk("t1_busy", 64'(busy), 64'd1);
      end
      chk("t1_valid_timing", 64'(cpi_valid), 64'(n == 41));
      if (n == 41) chk("t1_cpi", 64'(cpi_q), 64'h500);
      @(negedge clk);
    end
    chk("t1_cpi_hold", 64'(cpi_q), 64'h500);

    // zero instructions, then a request held across DONE
    clear = 1;
    @(negedge clk);
    clear = 0; enable = 1; snapshot_req = 1;
    @(negedge clk);
    chk("t2_valid", 64'(cpi_valid), 64'd1);
    chk("t2_dbz", 64'(div_by_zero), 64'd1);
    chk("t2_cpi", 64'(cpi_q), 64'hFFFF_FFFF);
    chk("t2_snap_cycles", 64'(snap_cycles), 64'd0);
    @(negedge clk);
    chk("t2_done_ignored", 64'(cpi_valid), 64'd0);
    chk("t2_snap_hold", 64'(snap_cycles), 64'd0);
    @(negedge clk);
    chk("t2_after_done_valid", 64'(cpi_valid), 64'd1);
    chk("t2_after_done_snap", 64'(snap_cycles), 64'd2);
    snapshot_req = 0; enable = 0;
    @(negedge clk);

    // second request during DIVIDE is dropped
    clear = 1;
    @(negedge clk);
    clear = 0; enable = 1; evt_inc = 4'b0101;
    for (int i = 0; i < 30; i++) begin
      instr_retire = (i % 3 == 0);
      @(negedge clk);
    end
    instr_retire = 0; snapshot_req = 1;
    @(negedge clk);
    snapshot_req = 0;
    pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      snapshot_req = (n == 5);
      instr_retire = (n < 20);
      if (n == 6 || n == 45) begin
        chk("t3_snap_cycles", 64'(snap_cycles), 64'd30);
        chk("t3_snap_instr", 64'(snap_instr), 64'd10);
        chk("t3_snap_evt0", 64'(snap_evt[31:0]), 64'd30);
      end
      if (cpi_valid) begin
        pulses++;
        chk("t3_cpi", 64'(cpi_q), 64'h300);
        chk("t3_valid_at", 64'(n), 64'd41);
      end
      @(negedge clk);
    end
    chk("t3_pulses", 64'(pulses), 64'd1);
    snapshot_req = 0; enable = 0; instr_retire = 0; evt_inc = '0;

    // clear, retire and snapshot in one cycle
    clear = 1;
    @(negedge clk);
    clear = 0; enable = 1; instr_retire = 1;
    repeat (7) @(negedge clk);
    clear = 1; snapshot_req = 1;
    @(negedge clk);
    clear = 0; snapshot_req = 0; enable = 0; instr_retire = 0;
    chk("t4_snap_cycles", 64'(snap_cycles), 64'd7);
    chk("t4_snap_instr", 64'(snap_instr), 64'd7);
    pulses = 0;
    for (int n = 1; n <= 45; n++) begin
      if (cpi_valid) begin
        pulses++;
        chk("t4_cpi", 64'(cpi_q), 64'h100);
      end
      @(negedge clk);
    end
    chk("t4_pulses", 64'(pulses), 64'd1);
    snapshot_req = 1;
    @(negedge clk);
    snapshot_req = 0;
    chk("t4_live_cycles_zero", 64'(snap_cycles), 64'd0);
    chk("t4_live_instr_zero", 64'(snap_instr), 64'd0);
    chk("t4_dbz", 64'(div_by_zero), 64'd1);
    @(negedge clk);

    // reset during DIVIDE cycle 10
    clear = 1;
    @(negedge clk);
    clear = 0; enable = 1;
    for (int i = 0; i < 16; i++) begin
      instr_retire = (i % 2 == 0);
      @(negedge clk);
    end
    enable = 0; instr_retire = 0; snapshot_req = 1;
    @(negedge clk);
    snapshot_req = 0;
    repeat (9) @(negedge clk);
    chk("t5_busy_before", 64'(busy), 64'd1);
    rst_n = 0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_valid", 64'(cpi_valid), 64'd0);
    chk("t5_rst_snap_cycles", 64'(snap_cycles), 64'd0);
    chk("t5_rst_snap_instr", 64'(snap_instr), 64'd0);
    chk("t5_rst_cpi", 64'(cpi_q), 64'd0);
    chk("t5_rst_dbz", 64'(div_by_zero), 64'd0);
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 50; n++) begin
      if (cpi_valid) pulses++;
      @(negedge clk);
    end
    chk("t5_no_valid", 64'(pulses), 64'd0);
    enable = 1;
    for (int i = 0; i < 40; i++) begin
      instr_retire = (i % 4 == 0);
      @(negedge clk);
    end
    enable = 0; instr_retire = 0; snapshot_req = 1;
    @(negedge clk);
    snapshot_req = 0;
    for (int n = 1; n <= 42; n++) begin
      chk("t5_valid_timing", 64'(cpi_valid), 64'(n == 41));
      if (n == 41) chk("t5_cpi", 64'(cpi_q), 64'h400);
      @(negedge clk);
    end

    // 8-bit instance: saturation and clear
    en8 = 1; evt8 = 4'b0001;
    repeat (300) @(negedge clk);
    en8 = 0; evt8 = '0; snap8 = 1;
    @(negedge clk);
    snap8 = 0;
    chk("t6_snap_evt0", 64'(snap_evt8[7:0]), 64'd255);
    chk("t6_snap_evt1", 64'(snap_evt8[15:8]), 64'd0);
    chk("t6_snap_cycles", 64'(snap_cycles8), 64'd255);
    chk("t6_ovf", 64'(ovf8), 64'b000101);
    chk("t6_cpi", 64'(cpi_q8), 64'hFF);
    @(negedge clk);
    clr8 = 1;
    @(negedge clk);
    clr8 = 0;
    chk("t6_ovf_clear", 64'(ovf8), 64'd0);
    snap8 = 1;
    @(negedge clk);
    snap8 = 0;
    chk("t6_live_evt_zero", 64'(snap_evt8[7:0]), 64'd0);
    chk("t6_live_cycles_zero", 64'(snap_cycles8), 64'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
